// File: rtl/spi_tx_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : spi_tx_sequencer_pkg
// | Purpose  : Shared encodings for the SPI init/host byte sequencer.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
package spi_tx_sequencer_pkg;

   localparam int c_ENTRY_W = 10;
   localparam int c_PTR_W   = 5;
   localparam int c_BYTE_W  = 8;
   localparam int c_CTRL_W  = 10;

   // Control word layout: {divider, dc, start}
   localparam int c_CTRL_START   = 0;
   localparam int c_CTRL_DC      = 1;
   localparam int c_CTRL_DIV_LSB = 2;
   localparam int c_CTRL_DIV_MSB = 9;

   typedef enum logic [1:0] {
      ENT_CMD   = 2'b00,
      ENT_DATA  = 2'b01,
      ENT_DELAY = 2'b10,
      ENT_END   = 2'b11
   } entry_type_t;

   localparam logic [2:0] c_ST_IDLE       = 3'd0;
   localparam logic [2:0] c_ST_FETCH      = 3'd1;
   localparam logic [2:0] c_ST_ISSUE      = 3'd2;
   localparam logic [2:0] c_ST_WAIT_VALID = 3'd3;
   localparam logic [2:0] c_ST_RELEASE    = 3'd4;
   localparam logic [2:0] c_ST_DELAY      = 3'd5;
   localparam logic [2:0] c_ST_READY      = 3'd6;
   localparam logic [2:0] c_ST_HOST_ISSUE = 3'd7;

   function automatic logic [c_ENTRY_W-1:0] rom_entry(input entry_type_t t,
                                                      input logic [c_BYTE_W-1:0] v);
      return {t, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : spi_tx_sequencer_if
// | Purpose  : Host byte handshake and SPI transmitter bus of the sequencer.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
interface spi_tx_sequencer_if;
   import spi_tx_sequencer_pkg::*;

   logic                  host_req;
   logic                  host_dc;
   logic [c_BYTE_W-1:0]   host_data;
   logic                  host_ack;
   logic [c_CTRL_W-1:0]   spi_control;
   logic [c_BYTE_W-1:0]   spi_data;
   logic                  spi_valid;

   modport slave (
      input  host_req, host_dc, host_data, spi_valid,
      output host_ack, spi_control, spi_data
   );

   modport master (
      output host_req, host_dc, host_data, spi_valid,
      input  host_ack, spi_control, spi_data
   );

endinterface
`default_nettype wire

// File: rtl/spi_tx_sequencer_init_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : spi_init_rom
// | Purpose  : Combinational init table; unused addresses read as END.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module spi_init_rom
   import spi_tx_sequencer_pkg::*;
(
   input  logic [c_PTR_W-1:0]   i_addr,
   output logic [c_ENTRY_W-1:0] o_entry
);

   always_comb begin
      case (i_addr)
         5'd0:    o_entry = rom_entry(ENT_CMD,   8'h11);
         5'd1:    o_entry = rom_entry(ENT_DELAY, 8'd2);
         5'd2:    o_entry = rom_entry(ENT_CMD,   8'h29);
         default: o_entry = rom_entry(ENT_END,   8'h00);
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/spi_tx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : spi_tx_sequencer
// | Purpose  : Plays the init ROM into an SPI transmitter, then serves host bytes.
// |            Define SPI_SEQ_DELAY_EN to execute DELAY entries (else skipped).
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module spi_tx_sequencer
   import spi_tx_sequencer_pkg::*;
#(
   parameter logic [7:0]  CLK_DIV      = 8'd24,
   parameter int unsigned TICKS_PER_MS = 100000,
   parameter int unsigned TIMEOUT      = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init_start,
   spi_tx_sequencer_if.slave  bus,
   output logic               busy,
   output logic               init_done,
   output logic               error
);

   localparam int c_TO_W = $clog2(TIMEOUT + 1);

   logic [2:0]            r_state;
   logic [c_PTR_W-1:0]    r_ptr;
   logic                  r_is_host;
   logic                  r_rel_done;
   logic                  r_start;
   logic                  r_dc;
   logic                  r_ack;
   logic                  r_init_done;
   logic                  r_error;
   logic [c_BYTE_W-1:0]   r_data;
   logic [c_TO_W-1:0]     r_wait_cnt;
   logic [c_ENTRY_W-1:0]  w_entry;
   entry_type_t           w_type;
   logic                  w_ptr_last;
   logic [2:0]            w_adv_state;
   logic [c_CTRL_W-1:0]   w_ctrl;

   spi_init_rom u_rom (
      .i_addr  (r_ptr),
      .o_entry (w_entry)
   );

   assign w_type      = entry_type_t'(w_entry[9:8]);
   // Stepping past entry 31 means the table has no END: abort to IDLE.
   assign w_ptr_last  = (r_ptr == 5'd31);
   assign w_adv_state = w_ptr_last ? c_ST_IDLE : c_ST_FETCH;

`ifdef SPI_SEQ_DELAY_EN
   localparam int c_DLY_W = $clog2(255 * TICKS_PER_MS + 1);
   logic [c_DLY_W-1:0] r_dly_cnt;
   logic [c_DLY_W-1:0] w_dly_load;
   assign w_dly_load = c_DLY_W'(w_entry[7:0] * TICKS_PER_MS);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_ST_IDLE;
         r_ptr       <= '0;
         r_is_host   <= 1'b0;
         r_rel_done  <= 1'b0;
         r_start     <= 1'b0;
         r_dc        <= 1'b0;
         r_ack       <= 1'b0;
         r_init_done <= 1'b0;
         r_error     <= 1'b0;
         r_data      <= '0;
         r_wait_cnt  <= '0;
`ifdef SPI_SEQ_DELAY_EN
         r_dly_cnt   <= '0;
`endif
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (init_start) begin
                  r_ptr   <= '0;
                  r_error <= 1'b0;
                  r_state <= c_ST_FETCH;
               end
            end
            c_ST_FETCH: begin
               case (w_type)
                  ENT_CMD, ENT_DATA: r_state <= c_ST_ISSUE;
                  ENT_DELAY: begin
`ifdef SPI_SEQ_DELAY_EN
                     r_dly_cnt <= w_dly_load;
                     r_state   <= c_ST_DELAY;
`else
                     r_ptr   <= r_ptr + 5'd1;
                     r_error <= r_error | w_ptr_last;
                     r_state <= w_adv_state;
`endif
                  end
                  default: begin
                     r_init_done <= 1'b1;
                     r_state     <= c_ST_READY;
                  end
               endcase
            end
            c_ST_ISSUE: begin
               r_data     <= w_entry[7:0];
               r_dc       <= w_entry[8];
               r_start    <= 1'b1;
               r_is_host  <= 1'b0;
               r_wait_cnt <= '0;
               r_state    <= c_ST_WAIT_VALID;
            end
            c_ST_HOST_ISSUE: begin
               r_data     <= bus.host_data;
               r_dc       <= bus.host_dc;
               r_start    <= 1'b1;
               r_is_host  <= 1'b1;
               r_wait_cnt <= '0;
               r_state    <= c_ST_WAIT_VALID;
            end
            c_ST_WAIT_VALID: begin
               if (bus.spi_valid) begin
                  r_start    <= 1'b0;
                  r_rel_done <= 1'b0;
                  r_state    <= c_ST_RELEASE;
               end else if (r_wait_cnt == c_TO_W'(TIMEOUT - 1)) begin
                  r_start <= 1'b0;
                  r_error <= 1'b1;
                  r_state <= c_ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
               end
            end
            c_ST_RELEASE: begin
               // Minimum two cycles here, then hold until the transmitter lets go.
               if (!r_rel_done) begin
                  r_rel_done <= 1'b1;
               end else if (!bus.spi_valid) begin
                  if (r_is_host) begin
                     r_ack   <= 1'b1;
                     r_state <= c_ST_READY;
                  end else begin
                     r_ptr   <= r_ptr + 5'd1;
                     r_error <= r_error | w_ptr_last;
                     r_state <= w_adv_state;
                  end
               end
            end
            c_ST_DELAY: begin
`ifdef SPI_SEQ_DELAY_EN
               if (r_dly_cnt <= c_DLY_W'(1)) begin
                  r_ptr   <= r_ptr + 5'd1;
                  r_error <= r_error | w_ptr_last;
                  r_state <= w_adv_state;
               end else begin
                  r_dly_cnt <= r_dly_cnt - c_DLY_W'(1);
               end
`else
               r_ptr   <= r_ptr + 5'd1;
               r_error <= r_error | w_ptr_last;
               r_state <= w_adv_state;
`endif
            end
            c_ST_READY: begin
               // The ack cycle blocks a still-high host_req from re-sending.
               if (init_start) begin
                  r_ptr       <= '0;
                  r_init_done <= 1'b0;
                  r_error     <= 1'b0;
                  r_state     <= c_ST_FETCH;
               end else if (bus.host_req && !r_ack) begin
                  r_state <= c_ST_HOST_ISSUE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_ctrl                                = '0;
      w_ctrl[c_CTRL_DIV_MSB:c_CTRL_DIV_LSB] = CLK_DIV;
      w_ctrl[c_CTRL_DC]                     = r_dc;
      w_ctrl[c_CTRL_START]                  = r_start;
   end

   assign bus.spi_control = w_ctrl;
   assign bus.spi_data    = r_data;
   assign bus.host_ack    = r_ack;
   assign busy            = (r_state != c_ST_IDLE) && (r_state != c_ST_READY);
   assign init_done       = r_init_done;
   assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : tb_spi_tx_sequencer
// | Purpose  : Randomized directed bench with a transmitter responder and ROM model.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_spi_tx_sequencer;

   localparam int         TICKS = 10;
   localparam int         TMO   = 64;
   localparam logic [7:0] DIV   = 8'd24;

   logic clk;
   logic reset;
   logic init_start;
   logic busy;
   logic init_done;
   logic error;

   spi_tx_sequencer_if bus();

   spi_tx_sequencer #(
      .CLK_DIV      (DIV),
      .TICKS_PER_MS (TICKS),
      .TIMEOUT      (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .init_start (init_start),
      .bus        (bus),
      .busy       (busy),
      .init_done  (init_done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Monitor state
   logic       prev_start = 1'b0;
   logic       prev_done  = 1'b0;
   logic [8:0] cur_xfer   = '0;
   logic [8:0] sent_q[$];
   int         rise_q[$];
   int         fall_q[$];
   int         unstable = 0;
   int         ack_cnt  = 0;
   int         ack_cyc  = 0;
   int         done_cyc = 0;

   // Transmitter responder knobs
   bit resp_en = 1'b1;
   int lat     = 20;
   int hold    = 1;
   int scnt    = 0;
   int vhold   = 0;

   // Reference model of the init table
   int         rom_kind[4] = '{0, 2, 0, 3};
   int         rom_val [4] = '{32'h11, 2, 32'h29, 0};
   logic [8:0] exp_q[$];
   int         exp_gap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_model();
      exp_q.delete();
      exp_gap = 0;
      for (int i = 0; i < 4; i++) begin
         if (rom_kind[i] == 3) break;
         if (rom_kind[i] == 2) exp_gap += rom_val[i] * TICKS;
         else exp_q.push_back({rom_kind[i][0], rom_val[i][7:0]});
      end
   endtask

   task automatic clear_mon();
      sent_q.delete();
      rise_q.delete();
      fall_q.delete();
      unstable = 0;
   endtask

   // One clock: sample outputs 1 time unit after the edge, then drive the responder.
   task automatic tick();
      logic st;
      logic [8:0] now_x;
      @(posedge clk);
      #1;
      cyc++;
      st    = bus.spi_control[0];
      now_x = {bus.spi_control[1], bus.spi_data};
      if (st && !prev_start) begin
         sent_q.push_back(now_x);
         rise_q.push_back(cyc);
         cur_xfer = now_x;
      end else if (st && prev_start && now_x !== cur_xfer) begin
         unstable++;
      end
      if (!st && prev_start) fall_q.push_back(cyc);
      if (bus.host_ack) begin
         ack_cnt++;
         ack_cyc = cyc;
      end
      if (init_done && !prev_done) done_cyc = cyc;
      prev_start = st;
      prev_done  = init_done;
      if (vhold > 0) begin
         bus.spi_valid = 1'b1;
         vhold--;
      end else if (resp_en && st) begin
         scnt++;
         if (scnt == lat) begin
            bus.spi_valid = 1'b1;
            vhold = hold - 1;
         end else begin
            bus.spi_valid = 1'b0;
         end
      end else begin
         scnt = 0;
         bus.spi_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 3000 && !init_done; k++) tick();
      check(tag, {31'b0, init_done}, 32'd1);
   endtask

   task automatic check_init_bytes(input string tag);
      check({tag, "_count"}, sent_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check({tag, "_byte"}, (i < sent_q.size()) ? {23'b0, sent_q[i]} : 32'hFFFF, {23'b0, exp_q[i]});
      check({tag, "_stable"}, unstable, 0);
   endtask

   task automatic do_host(input logic dc, input logic [7:0] d);
      int n0;
      int a0;
      logic [8:0] e;
      n0 = sent_q.size();
      a0 = ack_cnt;
      e  = {dc, d};
      bus.host_req  = 1'b1;
      bus.host_dc   = dc;
      bus.host_data = d;
      for (int k = 0; k < 400 && ack_cnt == a0; k++) tick();
      bus.host_req = 1'b0;
      check("host_ack_seen", ack_cnt - a0, 1);
      for (int k = 0; k < 6; k++) tick();
      check("host_ack_single", ack_cnt - a0, 1);
      check("host_xfer_count", sent_q.size() - n0, 1);
      check("host_byte", (sent_q.size() > n0) ? {23'b0, sent_q[n0]} : 32'hFFFF, {23'b0, e});
      check("host_stable", unstable, 0);
      check("host_idle_ready", {31'b0, busy}, 0);
   endtask

   initial begin
      int gap;
      int a0;
      logic       hdc;
      logic [7:0] hdata;

      reset         = 1'b1;
      init_start    = 1'b0;
      bus.host_req  = 1'b0;
      bus.host_dc   = 1'b0;
      bus.host_data = '0;
      bus.spi_valid = 1'b0;
      build_model();

      // Reset values
      for (int k = 0; k < 3; k++) tick();
      check("rst_control",   bus.spi_control, {22'b0, DIV, 2'b00});
      check("rst_data",      bus.spi_data, 0);
      check("rst_ack",       bus.host_ack, 0);
      check("rst_busy",      busy, 0);
      check("rst_init_done", init_done, 0);
      check("rst_error",     error, 0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("idle_busy", busy, 0);

      // ROM init sequence with a fixed 20-cycle transmitter
      clear_mon();
      lat = 20; hold = 1;
      init_start = 1'b1; tick(); init_start = 1'b0;
      check("init_busy", busy, 1);
      wait_done("init1_done");
      check_init_bytes("init1");
      gap = (rise_q.size() >= 2 && fall_q.size() >= 1) ? rise_q[1] - fall_q[0] : -1;
`ifdef SPI_SEQ_DELAY_EN
      check("init1_delay_gap", {31'b0, gap >= exp_gap}, 1);
`else
      check("init1_skip_gap", {31'b0, gap >= 0 && gap <= 5}, 1);
`endif
      check("init1_error", error, 0);
      check("init1_busy", busy, 0);

      // Directed host byte, then randomized host bytes
      do_host(1'b1, 8'hA5);
      for (int n = 0; n < 4; n++) begin
         lat  = $urandom_range(1, 30);
         hold = $urandom_range(1, 3);
         do_host(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      // Host request raised together with an init restart
      clear_mon();
      lat   = $urandom_range(2, 25);
      hold  = $urandom_range(1, 3);
      hdc   = 1'($urandom_range(0, 1));
      hdata = 8'($urandom_range(0, 255));
      a0    = ack_cnt;
      bus.host_req = 1'b1; bus.host_dc = hdc; bus.host_data = hdata;
      init_start = 1'b1; tick(); init_start = 1'b0;
      check("restart_clears_done", init_done, 0);
      for (int k = 0; k < 4; k++) tick();
      init_start = 1'b1; tick(); init_start = 1'b0;
      wait_done("init2_done");
      check("init2_no_early_ack", ack_cnt - a0, 0);
      for (int k = 0; k < 400 && ack_cnt == a0; k++) tick();
      bus.host_req = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      check("init2_ack_single", ack_cnt - a0, 1);
      check("init2_ack_after_done", {31'b0, ack_cyc > done_cyc}, 1);
      check("init2_count", sent_q.size(), exp_q.size() + 1);
      for (int i = 0; i < exp_q.size(); i++)
         check("init2_byte", (i < sent_q.size()) ? {23'b0, sent_q[i]} : 32'hFFFF, {23'b0, exp_q[i]});
      check("init2_host_byte", (sent_q.size() > exp_q.size()) ? {23'b0, sent_q[exp_q.size()]} : 32'hFFFF,
            {23'b0, hdc, hdata});

      // Transmitter never answers
      clear_mon();
      resp_en = 1'b0;
      init_start = 1'b1; tick(); init_start = 1'b0;
      for (int k = 0; k < 300 && fall_q.size() == 0; k++) tick();
      check("tmo_start_len", (rise_q.size() > 0 && fall_q.size() > 0) ? fall_q[0] - rise_q[0] : -1, TMO);
      check("tmo_error", error, 1);
      check("tmo_idle", busy, 0);
      check("tmo_byte", (sent_q.size() > 0) ? {23'b0, sent_q[0]} : 32'hFFFF, {23'b0, exp_q[0]});
      resp_en = 1'b1;
      lat = 20; hold = 1;
      clear_mon();
      init_start = 1'b1; tick(); init_start = 1'b0;
      check("tmo_error_cleared", error, 0);
      wait_done("init3_done");
      check_init_bytes("init3");

      // Asynchronous reset while waiting on the second init byte
      clear_mon();
      lat = 40;
      init_start = 1'b1; tick(); init_start = 1'b0;
      for (int k = 0; k < 500 && sent_q.size() < 2; k++) tick();
      for (int k = 0; k < 3; k++) tick();
      check("arst_pre_start", bus.spi_control[0], 1);
      a0 = ack_cnt;
      #2 reset = 1'b1;
      #1;
      check("arst_control",   bus.spi_control, {22'b0, DIV, 2'b00});
      check("arst_data",      bus.spi_data, 0);
      check("arst_busy",      busy, 0);
      check("arst_init_done", init_done, 0);
      check("arst_error",     error, 0);
      check("arst_ack",       bus.host_ack, 0);
      tick(); tick();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("arst_no_ack", ack_cnt - a0, 0);
      check("arst_idle", busy, 0);
      clear_mon();
      lat = 20;
      init_start = 1'b1; tick(); init_start = 1'b0;
      wait_done("init4_done");
      check_init_bytes("init4");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_tx_sequencer.md
SPI_TX_SEQUENCER -- requirements
Module: spi_tx_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 8'd24, SCL divider placed in spi_control[9:2].
REQ-002 The block SHALL have parameter TICKS_PER_MS, default 100000, clk cycles per millisecond of delay.
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, maximum clk cycles to wait for spi_valid.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, system clock.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port init_start, input, 1, pulse that starts the ROM init sequence.
REQ-008 The block SHALL have port host_req, input, 1, host byte request, level, held until host_ack.
REQ-009 The block SHALL have port host_dc, input, 1, host D/C bit (0 = command, 1 = data).
REQ-010 The block SHALL have port host_data, input, 8, host byte.
REQ-011 The block SHALL have port host_ack, output, 1, one-cycle pulse when the host byte completes.
REQ-012 The block SHALL have port spi_control, output, 10, {CLK_DIV, dc, start} to the SPI transmitter.
REQ-013 The block SHALL have port spi_data, output, 8, byte to the SPI transmitter.
REQ-014 The block SHALL have port spi_valid, input, 1, transmitter byte-done indication.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE and READY.
REQ-016 The block SHALL have port init_done, output, 1, sticky once the END entry is reached.
REQ-017 The block SHALL have port error, output, 1, sticky on spi_valid timeout.

Function
REQ-018 ROM entries SHALL be 10 bits: [9:8] type (00 CMD, 01 DATA, 10 DELAY, 11 END), [7:0] byte or ms count.
REQ-019 The FSM states SHALL be IDLE, FETCH, ISSUE, WAIT_VALID, RELEASE, DELAY, READY, HOST_ISSUE.
REQ-020 In IDLE, init_start SHALL clear the ROM pointer and move the FSM to FETCH.
REQ-021 FETCH SHALL take one cycle and dispatch on entry type: CMD/DATA to ISSUE, DELAY to DELAY, END to READY with init_done set.
REQ-022 ISSUE and HOST_ISSUE SHALL drive spi_data, dc = type[0] (or host_dc), start = 1, then enter WAIT_VALID.
REQ-023 start SHALL stay high until the first cycle spi_valid is sampled high; data and dc SHALL stay stable for that whole interval.
REQ-024 On spi_valid, start SHALL drop and the FSM SHALL enter RELEASE for at least 2 cycles, leaving only once spi_valid is low.
REQ-025 After RELEASE, a ROM transfer SHALL increment the pointer and go to FETCH; a host transfer SHALL pulse host_ack and go to READY.
REQ-026 DELAY SHALL count ms_count × TICKS_PER_MS cycles, then increment the pointer and go to FETCH; a count of 0 SHALL take one cycle.
REQ-027 In READY, host_req SHALL move the FSM to HOST_ISSUE; host_req in any other state SHALL be held off, with no ack.
REQ-028 init_start in READY SHALL restart the sequence, clearing init_done; init_start in a busy state SHALL be ignored.
REQ-029 The pointer SHALL be 5 bits; wrap from 31 to 0 without an END entry SHALL set error and return the FSM to IDLE.
REQ-030 If WAIT_VALID exceeds TIMEOUT cycles, the block SHALL set error, drop start and go to IDLE.
REQ-031 error SHALL clear only on reset or on the next init_start.

Reset
REQ-032 Reset SHALL set state IDLE, pointer 0, counters 0, spi_control {CLK_DIV, 0, 0}, spi_data 0, and host_ack, busy, init_done, error to 0.
REQ-033 Reset asserted mid-transfer SHALL drop start immediately (asynchronously), and no host_ack SHALL be issued.

Configuration
REQ-034 With SPI_SEQ_DELAY_EN defined, DELAY entries SHALL be executed as in REQ-026.
REQ-035 Without SPI_SEQ_DELAY_EN, DELAY entries SHALL be skipped in one cycle, and no delay counter SHALL be synthesised.

Structure
REQ-036 A shared package SHALL hold the entry-type encodings, the FSM state encoding, and the control-word field positions (start = 0, dc = 1, div = 9:2).
REQ-037 The init table SHALL be a sub-module spi_init_rom: 5-bit address in, 10-bit entry out, combinational.

Verification
REQ-038 ROM {CMD 0x11, DELAY 2, CMD 0x29, END}, TICKS_PER_MS = 10, model valid 20 cycles after start -> bytes 0x11 and 0x29 sent with dc = 0, ≥20-cycle gap between them, then init_done = 1.
REQ-039 In READY, host_req with dc = 1 and data 0xA5 -> spi_control[1] = 1, spi_data = 0xA5 until valid, then a single host_ack pulse.
REQ-040 host_req asserted during init -> no host_ack until after init_done; the host byte is then sent exactly once.
REQ-041 spi_valid never asserted, TIMEOUT = 64 -> start drops and error = 1 at cycle 64; the next init_start clears error.
REQ-042 Reset pulsed while in WAIT_VALID -> all outputs at reset values within the same cycle; init_start afterwards restarts from entry 0.
REQ-043 Build without SPI_SEQ_DELAY_EN using the ROM of REQ-038 -> 0x29 starts within 3 cycles after RELEASE of 0x11.
